pipe_drain: RTL and testbench

- Receiving end of the CPU's register-chain datapath: a DEPTH-stage pipeline register chain with valid/ready handshakes on both ends.
- Data enter at the head, advance one stage per clock, and leave at the tail only when the consumer accepts them.
- Bubbles collapse under backpressure, and a flush squashes all in-flight entries.
- Used between pipeline stages that can stall (e.g. EX->MEM->WB) and as a checkable reference for delay-chain behaviour in sim.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_drain_stage.sv | 44 ++++
 rtl/pipe_drain.sv | 80 ++++++++
 tb/tb_pipe_drain.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU register-chain datapath: default sizes,
// the per-stage register record and a popcount helper.
package pipe_pkg;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_WIDTH = 8;

  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH-1:0] dat;
  } stage_t;

  // Counts set bits of a vector zero-extended to 32 bits (DEPTH <= 32).
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned b = 0; b < 32; b++) begin
      n += {31'd0, v[b]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_drain_stage.sv
// One valid/data pipeline register. A load wins over a clear, so a stage that
// empties and refills on the same edge stays valid with the new word.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load_i) begin
      vld_d = 1'b1;
      dat_d = data_i;
    end else if (clear_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = dat_q;

endmodule

// File: rtl/pipe_drain.sv
// DEPTH-stage valid/ready register chain with collapsing bubbles and flush.
// Ready ripples combinationally from the tail back to the head each cycle.
module pipe_drain
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNTW-1:0]  count
);

  logic [DEPTH-1:0]            stage_vld;
  logic [DEPTH-1:0][WIDTH-1:0] stage_dat;
  logic [DEPTH-1:0][WIDTH-1:0] stage_src;
  logic [DEPTH-1:0]            adv, load, clr, vld_d;
  logic [CNTW-1:0]             count_q, count_d;
  logic                        accept;

  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = stage_vld[DEPTH-1] & out_ready & ~flush;
    for (int unsigned k = 0; k < DEPTH - 1; k++) begin
      adv[DEPTH-2-k] = stage_vld[DEPTH-2-k] & (~stage_vld[DEPTH-1-k] | adv[DEPTH-1-k]);
    end

    in_ready = rst & ~flush & (~stage_vld[0] | adv[0]);
    accept   = in_valid & in_ready;

    // Flush blocks every load and clears every stage; data registers keep their contents.
    load     = '0;
    load[0]  = accept;
    stage_src    = '0;
    stage_src[0] = in_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      load[k]      = adv[k-1] & ~flush;
      stage_src[k] = stage_dat[k-1];
    end
    clr   = adv | {DEPTH{flush}};
    vld_d = load | (stage_vld & ~clr);

    count_d = CNTW'(popcount(32'(vld_d)));
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (rst),
      .load_i (load[g]),
      .clear_i(clr[g]),
      .data_i (stage_src[g]),
      .vld_o  (stage_vld[g]),
      .data_o (stage_dat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_valid = rst & stage_vld[DEPTH-1] & ~flush;
  assign out_data  = rst ? stage_dat[DEPTH-1] : '0;
  assign count     = rst ? count_q : '0;

endmodule

// File: tb/tb_pipe_drain.sv
// Scoreboarded bench for pipe_drain: directed scenarios followed by random traffic,
// checked against a queue model of words and their earliest tail-arrival cycles.
module tb_pipe_drain;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CNTW-1:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_drain #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: FIFO of words in the chain. A word reaches the tail DEPTH
  // cycles after acceptance, or one cycle after the word ahead of it leaves.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               acc;
  } ent_t;

  ent_t q[$];
  int   cyc      = 0;
  int   last_pop = -1000;

  always @(negedge clk) begin
    bit ev;
    bit er;
    int rdy;
    ev = 1'b0;
    if (rst && !flush && q.size() > 0) begin
      rdy = q[0].acc + DEPTH;
      if (last_pop + 1 > rdy) rdy = last_pop + 1;
      ev = (cyc >= rdy);
    end
    er = rst && !flush && ((q.size() < DEPTH) || out_ready);

    chk("in_ready", int'(in_ready), int'(er));
    chk("out_valid", int'(out_valid), int'(ev));
    if (ev) chk("out_data", int'(out_data), int'(q[0].d));
    if (!rst) chk("out_data_rst", int'(out_data), 0);
    chk("count", int'(count), rst ? q.size() : 0);

    if (!rst) begin
      q.delete();
      last_pop = -1000;
    end else if (flush) begin
      q.delete();
    end else begin
      if (ev && out_ready) begin
        void'(q.pop_front());
        last_pop = cyc;
      end
      if (in_valid && er) q.push_back('{d: in_data, acc: cyc});
    end
    cyc++;
  end

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r,
                       input bit f = 1'b0, input bit rs = 1'b1);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rst       = rs;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b0, '0, r);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset then stream 1,2,3,... with the consumer always ready
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1 chk("rst_in_ready", int'(in_ready), 0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      if (i == 10) begin
        #1;
        chk("stream_count", int'(count), 4);
        chk("stream_data", int'(out_data), 6);
      end
    end
    idle(8, 1'b1);

    // Backpressure fill to capacity, then a single pop
    drive(1'b1, 8'hA1, 1'b0);
    drive(1'b1, 8'hA2, 1'b0);
    drive(1'b1, 8'hA3, 1'b0);
    drive(1'b1, 8'hA4, 1'b0);
    idle(4, 1'b0);
    #1;
    chk("bp_count", int'(count), 4);
    chk("bp_data", int'(out_data), 'hA1);
    chk("bp_in_ready", int'(in_ready), 0);
    drive(1'b0, '0, 1'b1);
    #1 chk("bp_pop_ready", int'(in_ready), 1);
    drive(1'b0, '0, 1'b0);
    #1;
    chk("bp_count_after", int'(count), 3);
    chk("bp_data_after", int'(out_data), 'hA2);
    idle(8, 1'b1);

    // Bubble collapse
    drive(1'b1, 8'h10, 1'b0);
    idle(2, 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    idle(4, 1'b0);
    #1;
    chk("bubble_count", int'(count), 2);
    chk("bubble_head", int'(out_data), 'h10);
    drive(1'b0, '0, 1'b1);
    #1 chk("bubble_out0", int'(out_data), 'h10);
    drive(1'b0, '0, 1'b1);
    #1;
    chk("bubble_out1", int'(out_data), 'h20);
    chk("bubble_valid1", int'(out_valid), 1);
    idle(6, 1'b1);

    // Full chain, simultaneous push and pop
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0);
    idle(4, 1'b0);
    drive(1'b1, 8'h05, 1'b1);
    #1;
    chk("pp_in_ready", int'(in_ready), 1);
    chk("pp_out", int'(out_data), 'h01);
    drive(1'b0, '0, 1'b0);
    #1;
    chk("pp_count", int'(count), 4);
    chk("pp_next", int'(out_data), 'h02);
    idle(10, 1'b1);

    // Flush with a push attempt in the same cycle
    drive(1'b1, 8'h31, 1'b0);
    drive(1'b1, 8'h32, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    idle(1, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    #1;
    chk("fl_in_ready", int'(in_ready), 0);
    chk("fl_out_valid", int'(out_valid), 0);
    drive(1'b0, '0, 1'b1);
    #1 chk("fl_count", int'(count), 0);
    idle(8, 1'b1);

    // Reset in the middle of a full chain
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    idle(4, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0);
    #1;
    chk("mr_valid", int'(out_valid), 0);
    chk("mr_data", int'(out_data), 0);
    chk("mr_count", int'(count), 0);
    drive(1'b1, 8'h77, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, '0, 1'b1);
      if (i == 4) begin
        #1;
        chk("mr_lat_valid", int'(out_valid), 1);
        chk("mr_lat_data", int'(out_data), 'h77);
      end
    end

    // Random traffic with occasional flush and reset
    for (int blk = 0; blk < 30; blk++) begin
      int unsigned rp;
      rp = $urandom_range(1, 9);
      for (int i = 0; i < 100; i++) begin
        drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < rp,
              $urandom_range(0, 39) == 0, $urandom_range(0, 199) != 0);
      end
    end
    idle(10, 1'b1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
